// File: rtl/fnd_pkg.sv
// Shared constants for the FND display path: segment font, count limit,
// converter state encoding and the font/double-dabble helpers.
package fnd_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [13:0] MAX_COUNT = 14'd9999;

  // Segments {dp,g,f,e,d,c,b,a}, active-low, dp held off
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } b2b_state_t;

  function automatic logic [7:0] seg_font(input logic [3:0] d);
    logic [7:0] f;
    case (d)
      4'd0:    f = SEG_0;
      4'd1:    f = SEG_1;
      4'd2:    f = SEG_2;
      4'd3:    f = SEG_3;
      4'd4:    f = SEG_4;
      4'd5:    f = SEG_5;
      4'd6:    f = SEG_6;
      4'd7:    f = SEG_7;
      4'd8:    f = SEG_8;
      4'd9:    f = SEG_9;
      default: f = SEG_BLANK;
    endcase
    return f;
  endfunction

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift
  function automatic logic [15:0] dabble_adj(input logic [15:0] b);
    logic [15:0] r;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? (b[i*4 +: 4] + 4'd3) : b[i*4 +: 4];
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 14-bit count (clamped to 9999) to four
// BCD digits, with a 1-deep newest-wins pending slot for strobes while busy.
//
//   state    | meaning
//   ST_IDLE  | waiting for a strobe or a pending value
//   ST_SHIFT | 14 add-3/shift iterations on {acc, shreg}
//   ST_DONE  | publish accumulator to digits, return to idle
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] count,
  input  logic        count_valid,
  output logic        busy,
  output logic [15:0] digits
);

  b2b_state_t  state;
  logic [13:0] shreg;
  logic [15:0] acc;
  logic [3:0]  iter;
  logic        pend_vld;
  logic [13:0] pend_val;
  logic [13:0] clamped;

  assign clamped = (count > MAX_COUNT) ? MAX_COUNT : count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      acc      <= '0;
      iter     <= '0;
      pend_vld <= 1'b0;
      pend_val <= '0;
      busy     <= 1'b0;
      digits   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // A fresh strobe is newer than anything pending, so it wins
          if (count_valid || pend_vld) begin
            shreg    <= count_valid ? clamped : pend_val;
            acc      <= '0;
            iter     <= '0;
            pend_vld <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc   <= (dabble_adj(acc) << 1) | 16'(shreg[13]);
          shreg <= shreg << 1;
          iter  <= iter + 4'd1;
          if (iter == 4'd13) state <= ST_DONE;
        end
        ST_DONE: begin
          digits <= acc;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase

      if (count_valid && (state != ST_IDLE)) begin
        pend_vld <= 1'b1;
        pend_val <= clamped;
      end
    end
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// 4-digit common-anode FND scanner: converts the binary count to BCD and
// time-multiplexes the digits with optional leading-zero blanking.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV = 100_000,
  parameter int BLANK_LZ = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] count,
  input  logic        count_valid,
  output logic        bcd_busy,
  output logic [3:0]  fnd_com,
  output logic [7:0]  fnd_font
);

  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [15:0]   digits;
  logic [TW-1:0] tick;
  logic [1:0]    idx;
  logic [3:0]    blank;
  logic [3:0]    cur_digit;

  bin2bcd_seq u_bin2bcd (
    .clk         (clk),
    .rst         (rst),
    .count       (count),
    .count_valid (count_valid),
    .busy        (bcd_busy),
    .digits      (digits)
  );

  // Blanking cascades downward from the thousands digit; ones is always lit
  always_comb begin
    blank    = 4'b0000;
    blank[3] = (BLANK_LZ != 0) && (digits[15:12] == 4'd0);
    blank[2] = blank[3] && (digits[11:8] == 4'd0);
    blank[1] = blank[2] && (digits[7:4] == 4'd0);
  end

  always_comb begin
    cur_digit = digits[3:0];
    case (idx)
      2'd0: cur_digit = digits[3:0];
      2'd1: cur_digit = digits[7:4];
      2'd2: cur_digit = digits[11:8];
      2'd3: cur_digit = digits[15:12];
      default: cur_digit = digits[3:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick     <= '0;
      idx      <= '0;
      fnd_com  <= 4'hF;
      fnd_font <= SEG_BLANK;
    end else begin
      if (tick == TW'(SCAN_DIV - 1)) begin
        tick <= '0;
        idx  <= idx + 2'd1;
      end else begin
        tick <= tick + 1'b1;
      end
      fnd_com  <= ~(4'b0001 << idx);
      fnd_font <= blank[idx] ? SEG_BLANK : seg_font(cur_digit);
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl: two instances (blanking on/off) share stimulus;
// each scan frame is captured per anode and compared to hand-computed fonts.
module tb_fnd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [13:0] count = '0;
  logic        count_valid = 1'b0;
  logic        busy_a, busy_b;
  logic [3:0]  com_a, com_b;
  logic [7:0]  font_a, font_b;

  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  fa[4];
  logic [7:0]  fb[4];
  int          seen[4];
  logic        mon_en = 1'b0;
  logic        frag_seen = 1'b0;

  fnd_scan_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1)) u_dut_a (
    .clk(clk), .rst(rst), .count(count), .count_valid(count_valid),
    .bcd_busy(busy_a), .fnd_com(com_a), .fnd_font(font_a)
  );

  fnd_scan_ctrl #(.SCAN_DIV(4), .BLANK_LZ(0)) u_dut_b (
    .clk(clk), .rst(rst), .count(count), .count_valid(count_valid),
    .bcd_busy(busy_b), .fnd_com(com_b), .fnd_font(font_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en && (font_a inside {8'h92, 8'h82, 8'hF8, 8'h80})) frag_seen = 1'b1;
  end

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic [13:0] v);
    count       = v;
    count_valid = 1'b1;
    @(negedge clk);
    count_valid = 1'b0;
  endtask

  // Samples 16 consecutive clocks (one full frame at SCAN_DIV=4)
  task automatic read_frame();
    for (int k = 0; k < 4; k++) begin
      fa[k] = 8'h00;
      fb[k] = 8'h00;
      seen[k] = 0;
    end
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (com_a == ~(4'b0001 << k)) begin
          fa[k] = font_a;
          seen[k]++;
        end
        if (com_b == ~(4'b0001 << k)) fb[k] = font_b;
      end
      @(negedge clk);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [31:0] exp_a, input logic [31:0] exp_b);
    chk({tag, "_a"}, {fa[3], fa[2], fa[1], fa[0]}, exp_a);
    chk({tag, "_b"}, {fb[3], fb[2], fb[1], fb[0]}, exp_b);
  endtask

  task automatic convert(input string tag, input logic [13:0] v,
                         input logic [31:0] exp_a, input logic [31:0] exp_b);
    int n;
    strobe(v);
    n = 0;
    while (busy_a && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_len"}, n, 15);
    @(negedge clk);
    read_frame();
    chk_frame(tag, exp_a, exp_b);
  endtask

  task automatic back_to_back();
    int n;
    int n2;
    strobe(14'd42);
    repeat (3) @(negedge clk);
    strobe(14'd17);
    repeat (3) @(negedge clk);
    strobe(14'd99);
    n = 0;
    while (busy_a && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("b2b_first_done", busy_a, 1'b0);
    n = 0;
    while (!busy_a && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("b2b_idle_gap", n, 1);
    n2 = 0;
    fork
      read_frame();
      begin
        while (busy_a && n2 < 100) begin
          n2++;
          @(negedge clk);
        end
      end
    join
    chk("b2b_busy2_len", n2, 15);
    chk_frame("b2b_42", 32'hFFFF99A4, 32'hC0C099A4);
    read_frame();
    chk_frame("b2b_99", 32'hFFFF9090, 32'hC0C09090);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_com", com_a, 4'hF);
    chk("rst_font", font_a, 8'hFF);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_b_outs", {busy_b, com_b, font_b}, {1'b0, 4'hF, 8'hFF});

    rst = 1'b1;
    @(negedge clk);
    chk("first_com", com_a, 4'b1110);
    chk("first_font", font_a, 8'hC0);

    read_frame();
    chk_frame("zero", 32'hFFFFFFC0, 32'hC0C0C0C0);
    for (int k = 0; k < 4; k++) chk($sformatf("slot_len%0d", k), seen[k], 4);

    convert("c1234", 14'd1234,    32'hF9A4B099, 32'hF9A4B099);
    convert("c7",    14'd7,       32'hFFFFFFF8, 32'hC0C0C0F8);
    convert("c1005", 14'd1005,    32'hF9C0C092, 32'hF9C0C092);
    convert("c50",   14'd50,      32'hFFFF92C0, 32'hC0C092C0);
    convert("c9998", 14'd9998,    32'h90909080, 32'h90909080);
    convert("c3fff", 14'h3FFF,    32'h90909090, 32'h90909090);
    convert("c10000", 14'd10000,  32'h90909090, 32'h90909090);

    back_to_back();

    frag_seen = 1'b0;
    mon_en    = 1'b1;
    strobe(14'd5678);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", busy_a, 1'b0);
    chk("midrst_com", com_a, 4'hF);
    chk("midrst_font", font_a, 8'hFF);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_first", {com_a, font_a}, {4'b1110, 8'hC0});
    read_frame();
    chk_frame("midrst_zero", 32'hFFFFFFC0, 32'hC0C0C0C0);
    chk("midrst_idle", busy_a, 1'b0);
    chk("midrst_no_fragment", frag_seen, 1'b0);
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
